// File: rtl/cpu_bus_pkg.sv
// Shared sram-like bus types and widths for the CPU bus arbiter.
package cpu_bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 2;

    localparam logic [SIZE_W-1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } arb_state_t;

    // Request payload forwarded from the granted master to the slave
    typedef struct packed {
        logic              wr;
        logic [SIZE_W-1:0] size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } sram_cmd_t;

endpackage

// File: rtl/sramlike_arbiter.sv
// Two-master (inst/data) to one-slave sram-like arbiter: one outstanding
// transaction, data-side priority with an instruction starvation guard.
module sramlike_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [SIZE_W-1:0] inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [SIZE_W-1:0] data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              req,
    output logic              wr,
    output logic [SIZE_W-1:0] size,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic              addr_ok,
    input  logic              data_ok,
    input  logic [DATA_W-1:0] rdata
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gnt_i, gnt_d;
    sram_cmd_t        cmd;

    // Fixed data priority, yielding once the data side has won STARVE_LIMIT times
    always_comb begin
        gnt_d = data_req && !(inst_req && (cnt_q == CNT_MAX));
        gnt_i = inst_req && !gnt_d;
    end

    // State register and starvation counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, grant muxing and handshake routing; everything quiet in reset
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req          = 1'b0;
        cmd          = '0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;

        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (gnt_d) begin
                        cmd = {data_wr, data_size, data_addr, data_wdata};
                    end else if (gnt_i) begin
                        cmd = {inst_wr, inst_size, inst_addr, inst_wdata};
                    end
                    req          = gnt_d || gnt_i;
                    inst_addr_ok = addr_ok && gnt_i;
                    data_addr_ok = addr_ok && gnt_d;
                    if (addr_ok && gnt_d) begin
                        state_d = WAIT_D;
                        if (inst_req && (cnt_q != CNT_MAX)) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (addr_ok && gnt_i) begin
                        state_d = WAIT_I;
                        cnt_d   = '0;
                    end
                end
                WAIT_I: begin
                    inst_data_ok = data_ok;
                    if (data_ok) begin
                        state_d = IDLE;
                    end
                end
                WAIT_D: begin
                    data_data_ok = data_ok;
                    if (data_ok) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Slave-side payload and shared read-data fan-out
    assign wr         = cmd.wr;
    assign size       = cmd.size;
    assign addr       = cmd.addr;
    assign wdata      = cmd.wdata;
    assign inst_rdata = rdata;
    assign data_rdata = rdata;

endmodule

// File: tb/tb_sramlike_arbiter.sv
// Directed bench for sramlike_arbiter (STARVE_LIMIT = 4).
module tb_sramlike_arbiter;
    import cpu_bus_pkg::*;

    logic        clk;
    logic        rst;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;

    int errors = 0;
    int checks = 0;

    sramlike_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic quiet_inputs();
        inst_req = 0; inst_wr = 0; inst_size = SIZE_WORD; inst_addr = '0; inst_wdata = '0;
        data_req = 0; data_wr = 0; data_size = SIZE_WORD; data_addr = '0; data_wdata = '0;
        addr_ok = 0; data_ok = 0; rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1;
        inst_req = 1; data_req = 1; addr_ok = 1; data_ok = 1;
        @(negedge clk); #1;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req got=%0b exp=0", req); end
        checks++; if (inst_addr_ok !== 1'b0) begin errors++; $display("FAIL reset_inst_addr_ok got=%0b exp=0", inst_addr_ok); end
        checks++; if (data_addr_ok !== 1'b0) begin errors++; $display("FAIL reset_data_addr_ok got=%0b exp=0", data_addr_ok); end
        checks++; if (inst_data_ok !== 1'b0) begin errors++; $display("FAIL reset_inst_data_ok got=%0b exp=0", inst_data_ok); end
        checks++; if (data_data_ok !== 1'b0) begin errors++; $display("FAIL reset_data_data_ok got=%0b exp=0", data_data_ok); end
        @(negedge clk);
        quiet_inputs();
        rst = 0;
    endtask

    task automatic test_inst_read();
        @(negedge clk);
        inst_req = 1; inst_addr = 32'hBFC0_0000; addr_ok = 1; #1;
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL ird_req got=%0b exp=1", req); end
        checks++; if (addr !== 32'hBFC0_0000) begin errors++; $display("FAIL ird_addr got=%h exp=bfc00000", addr); end
        checks++; if (size !== 2'b10) begin errors++; $display("FAIL ird_size got=%b exp=10", size); end
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL ird_wr got=%0b exp=0", wr); end
        checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("FAIL ird_inst_addr_ok got=%0b exp=1", inst_addr_ok); end
        checks++; if (data_addr_ok !== 1'b0) begin errors++; $display("FAIL ird_data_addr_ok got=%0b exp=0", data_addr_ok); end
        @(negedge clk);
        inst_req = 0; addr_ok = 0; #1;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL ird_wait_req got=%0b exp=0", req); end
        @(negedge clk);
        @(negedge clk);
        data_ok = 1; rdata = 32'h3C08_0001; #1;
        checks++; if (inst_data_ok !== 1'b1) begin errors++; $display("FAIL ird_inst_data_ok got=%0b exp=1", inst_data_ok); end
        checks++; if (inst_rdata !== 32'h3C08_0001) begin errors++; $display("FAIL ird_inst_rdata got=%h exp=3c080001", inst_rdata); end
        checks++; if (data_rdata !== 32'h3C08_0001) begin errors++; $display("FAIL ird_data_rdata got=%h exp=3c080001", data_rdata); end
        checks++; if (data_data_ok !== 1'b0) begin errors++; $display("FAIL ird_data_data_ok got=%0b exp=0", data_data_ok); end
        @(negedge clk);
        data_ok = 0; rdata = '0; #1;
        checks++; if (inst_data_ok !== 1'b0) begin errors++; $display("FAIL ird_one_cycle got=%0b exp=0", inst_data_ok); end
    endtask

    task automatic test_priority();
        @(negedge clk);
        inst_req = 1; inst_addr = 32'hBFC0_0004;
        data_req = 1; data_wr = 1; data_addr = 32'h8000_1000; data_wdata = 32'hDEAD_BEEF;
        addr_ok = 1; #1;
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL pri_req got=%0b exp=1", req); end
        checks++; if (wr !== 1'b1) begin errors++; $display("FAIL pri_wr got=%0b exp=1", wr); end
        checks++; if (addr !== 32'h8000_1000) begin errors++; $display("FAIL pri_addr got=%h exp=80001000", addr); end
        checks++; if (wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL pri_wdata got=%h exp=deadbeef", wdata); end
        checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL pri_data_addr_ok got=%0b exp=1", data_addr_ok); end
        checks++; if (inst_addr_ok !== 1'b0) begin errors++; $display("FAIL pri_inst_addr_ok got=%0b exp=0", inst_addr_ok); end
        // WAIT_D: pending inst request and a stray addr_ok must not leak through
        @(negedge clk);
        data_req = 0; data_wr = 0; #1;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL waitd_req got=%0b exp=0", req); end
        checks++; if (inst_addr_ok !== 1'b0) begin errors++; $display("FAIL waitd_inst_addr_ok got=%0b exp=0", inst_addr_ok); end
        @(negedge clk);
        addr_ok = 0; data_ok = 1; #1;
        checks++; if (data_data_ok !== 1'b1) begin errors++; $display("FAIL pri_data_data_ok got=%0b exp=1", data_data_ok); end
        checks++; if (inst_data_ok !== 1'b0) begin errors++; $display("FAIL pri_inst_data_ok got=%0b exp=0", inst_data_ok); end
        @(negedge clk);
        data_ok = 0; addr_ok = 1; #1;
        checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("FAIL pri_inst_next got=%0b exp=1", inst_addr_ok); end
        checks++; if (addr !== 32'hBFC0_0004) begin errors++; $display("FAIL pri_inst_addr got=%h exp=bfc00004", addr); end
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL pri_inst_wr got=%0b exp=0", wr); end
        @(negedge clk);
        inst_req = 0; addr_ok = 0; data_ok = 1; #1;
        checks++; if (inst_data_ok !== 1'b1) begin errors++; $display("FAIL pri_inst_done got=%0b exp=1", inst_data_ok); end
        @(negedge clk);
        data_ok = 0;
    endtask

    task automatic test_starvation();
        logic [5:0] exp_d;
        exp_d = 6'b101111;   // t0..t3 data, t4 instruction, t5 data
        inst_addr = 32'hBFC0_0008; data_addr = 32'h8000_2000;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            data_ok = 0; inst_req = 1; data_req = 1; addr_ok = 1; #1;
            checks++; if (data_addr_ok !== exp_d[t]) begin errors++; $display("FAIL starve_data_gnt t=%0d got=%0b exp=%0b", t, data_addr_ok, exp_d[t]); end
            checks++; if (inst_addr_ok !== !exp_d[t]) begin errors++; $display("FAIL starve_inst_gnt t=%0d got=%0b exp=%0b", t, inst_addr_ok, !exp_d[t]); end
            @(negedge clk);
            addr_ok = 0; data_ok = 1; #1;
            checks++; if (data_data_ok !== exp_d[t]) begin errors++; $display("FAIL starve_data_ok t=%0d got=%0b exp=%0b", t, data_data_ok, exp_d[t]); end
        end
        @(negedge clk);
        data_ok = 0; inst_req = 0; data_req = 0;
    endtask

    task automatic test_spurious();
        @(negedge clk);
        data_ok = 1; #1;
        checks++; if (inst_data_ok !== 1'b0) begin errors++; $display("FAIL spur_inst_data_ok got=%0b exp=0", inst_data_ok); end
        checks++; if (data_data_ok !== 1'b0) begin errors++; $display("FAIL spur_data_data_ok got=%0b exp=0", data_data_ok); end
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL spur_req got=%0b exp=0", req); end
        @(negedge clk);
        data_ok = 0; data_req = 1; addr_ok = 1; #1;
        checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL spur_still_idle got=%0b exp=1", data_addr_ok); end
        @(negedge clk);
        data_req = 0; addr_ok = 0; data_ok = 1; #1;
        checks++; if (data_data_ok !== 1'b1) begin errors++; $display("FAIL spur_done got=%0b exp=1", data_data_ok); end
        @(negedge clk);
        data_ok = 0;
    endtask

    task automatic test_regrant();
        @(negedge clk);
        inst_req = 1; inst_addr = 32'hBFC0_0010; #1;
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL regrant_req got=%0b exp=1", req); end
        checks++; if (inst_addr_ok !== 1'b0) begin errors++; $display("FAIL regrant_no_ack got=%0b exp=0", inst_addr_ok); end
        @(negedge clk);
        inst_req = 0; data_req = 1; data_addr = 32'h8000_3000; addr_ok = 1; #1;
        checks++; if (addr !== 32'h8000_3000) begin errors++; $display("FAIL regrant_addr got=%h exp=80003000", addr); end
        checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL regrant_data got=%0b exp=1", data_addr_ok); end
        @(negedge clk);
        data_req = 0; addr_ok = 0; data_ok = 1;
        @(negedge clk);
        data_ok = 0;
    endtask

    task automatic test_reset_mid();
        // Reset while an instruction fetch is outstanding
        @(negedge clk);
        inst_req = 1; addr_ok = 1; #1;
        checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("FAIL rmid_inst_gnt got=%0b exp=1", inst_addr_ok); end
        @(negedge clk);
        rst = 1; data_ok = 1; #1;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL rmid_req got=%0b exp=0", req); end
        checks++; if (inst_data_ok !== 1'b0) begin errors++; $display("FAIL rmid_in_rst_data_ok got=%0b exp=0", inst_data_ok); end
        @(negedge clk);
        rst = 0; inst_req = 0; addr_ok = 0; data_ok = 1; #1;
        checks++; if (inst_data_ok !== 1'b0) begin errors++; $display("FAIL rmid_lost_resp got=%0b exp=0", inst_data_ok); end
        checks++; if (data_data_ok !== 1'b0) begin errors++; $display("FAIL rmid_data_data_ok got=%0b exp=0", data_data_ok); end
        // Saturate the counter, park in WAIT_D, then reset: data must win again
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            data_ok = 0; inst_req = (i < 4); data_req = 1; addr_ok = 1; #1;
            checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL rmid_pump i=%0d got=%0b exp=1", i, data_addr_ok); end
            @(negedge clk);
            data_req = 0; addr_ok = 0; data_ok = (i < 4);
        end
        @(negedge clk);
        rst = 1; #1;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL rmid_waitd_req got=%0b exp=0", req); end
        @(negedge clk);
        rst = 0; inst_req = 1; data_req = 1; addr_ok = 1; #1;
        checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL rmid_cnt_clear_data got=%0b exp=1", data_addr_ok); end
        checks++; if (inst_addr_ok !== 1'b0) begin errors++; $display("FAIL rmid_cnt_clear_inst got=%0b exp=0", inst_addr_ok); end
        @(negedge clk);
        inst_req = 0; data_req = 0; addr_ok = 0; data_ok = 1;
        @(negedge clk);
        data_ok = 0;
    endtask

    initial begin
        quiet_inputs();
        rst = 1;
        test_reset();
        test_inst_read();
        test_priority();
        test_starvation();
        test_spurious();
        test_regrant();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sramlike_arbiter.md
# sramlike_arbiter

Two-master to one-slave arbiter on the CPU's sram-like bus (req / addr_ok / data_ok handshake). The instruction-side and data-side sram-like bridges each drive one master port. The single slave port feeds the cache/AXI bridge. The arbiter allows exactly one outstanding transaction, gives the data side fixed priority with a starvation guard for instruction fetch, and routes addr_ok/data_ok back to the owning master only.

## Interface
- STARVE_LIMIT, 4: number of consecutive data grants allowed while inst_req is pending before one instruction grant is forced (≥1).
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- inst_req, inst_wr  in  1 each  instruction master request / write flag
- inst_size  in  2  transfer size
- inst_addr, inst_wdata  in  32 each  instruction master address / write data
- inst_addr_ok, inst_data_ok  out  1 each  address accepted / data returned, instruction master
- inst_rdata  out  32  read data, instruction master
- data_req, data_wr, data_size, data_addr, data_wdata, data_addr_ok, data_data_ok, data_rdata: same widths and directions as the inst_* set, for the data master
- req, wr  out  1 each  slave request / write flag
- size  out  2  slave transfer size
- addr, wdata  out  32 each  slave address / write data
- addr_ok, data_ok  in  1 each  slave handshakes
- rdata  in  32  slave read data

## Operation
- FSM states:
  - IDLE: no transaction outstanding.
  - WAIT_I: instruction transaction outstanding.
  - WAIT_D: data transaction outstanding.
- Reset value: IDLE, starve_cnt=0.
- Grant in IDLE (combinational from current requests):
  - gnt_d = data_req && !(inst_req && starve_cnt==STARVE_LIMIT).
  - gnt_i = inst_req && !gnt_d.
- IDLE slave outputs:
  - req = gnt_d|gnt_i.
  - wr/size/addr/wdata muxed from the granted master; all-zero when no grant.
- IDLE addr_ok routing: inst_addr_ok = addr_ok&&gnt_i; data_addr_ok = addr_ok&&gnt_d.
- IDLE transitions: req&&addr_ok → WAIT_I (gnt_i) or WAIT_D (gnt_d).
- WAIT_I / WAIT_D slave outputs:
  - req=0, both *_addr_ok=0.
  - inst_data_ok = data_ok && state==WAIT_I; data_data_ok = data_ok && state==WAIT_D.
- WAIT_I / WAIT_D transitions: data_ok → IDLE.
- data_ok in IDLE is spurious: ignored, not forwarded.
- inst_rdata = data_rdata = rdata (unconditional); only data_ok qualifies it.
- starve_cnt, width $clog2(STARVE_LIMIT+1):
  - +1, saturating at STARVE_LIMIT, on a data handshake while inst_req=1.
  - Cleared on an instruction handshake.
  - Held otherwise.
- Writes and reads are sequenced identically; data_ok completes both.

## Timing
- Added latency is 0 cycles. req, addr_ok and data_ok are combinational pass-through in the permitted state.
- A new request can be accepted no earlier than the cycle after data_ok, which gives a minimum of 2 cycles per transaction.
- If addr_ok and data_ok arrive in the same cycle in IDLE, the handshake completes and the FSM enters WAIT_x. The data_ok is ignored (the slave must not do this).
- A master may drop req before addr_ok; the grant re-evaluates every IDLE cycle, so there is no lock-in until the handshake.
- Reset mid-transaction: FSM → IDLE and counter → 0 asynchronously. All *_ok outputs and req drop immediately, and the outstanding response is lost.
- During reset: req=0, all *_addr_ok/*_data_ok=0.

## Structure
- Shared package cpu_bus_pkg:
  - arb_state_t enum (IDLE, WAIT_I, WAIT_D).
  - SIZE_WORD=2'b10.
  - Sram-like bus field widths (ADDR_W=32, DATA_W=32).
- No sub-module is needed. The grant logic, FSM and starvation counter fit in one module.

## Test plan
- Reset held, then inst_req=1 addr=0xBFC00000, slave addr_ok=1 → req=1, addr=0xBFC00000, inst_addr_ok=1, data_addr_ok=0. State WAIT_I. Slave data_ok with rdata=0x3C080001 two cycles later → inst_data_ok=1 and inst_rdata=0x3C080001 for one cycle, data_data_ok=0.
- inst_req and data_req both 1 (data_addr=0x80001000, wr=1, wdata=0xDEADBEEF) → data side granted first. The slave sees wr=1 and wdata=0xDEADBEEF. After data_ok, the instruction side is granted on the next cycle.
- data_req held high continuously with inst_req pending, STARVE_LIMIT=4 → exactly 4 data grants, then 1 instruction grant, then data resumes.
- In WAIT_D, inst_req asserted and slave addr_ok=1 → req=0, inst_addr_ok=0 until data_ok.
- data_ok pulse in IDLE with no request → neither *_data_ok asserts, state stays IDLE.
- rst asserted in WAIT_I, then data_ok arrives after rst release → state IDLE, inst_data_ok=0, starve_cnt=0.
